// File: rtl/tanh_series_engine.sv
// Sequenced signed fixed-point tanh(x) via the Maclaurin series with a single shared multiplier.
// Optional build macro TANH_ROUND_EN selects round-half-up products instead of truncation.
module tanh_series_engine #(
    parameter int WIDTH  = 16,
    parameter int NTERMS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y_out
);

    localparam int KW = (NTERMS > 1) ? $clog2(NTERMS) : 1;
    localparam int AW = WIDTH + 2;
    localparam int PW = 2 * WIDTH + 2;
    localparam logic [KW-1:0] K_LAST = KW'(NTERMS - 1);
    localparam logic signed [PW-1:0] SMAX = {{(WIDTH+3){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{(WIDTH+3){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SQR, RMUL, XMUL, ACC, FIN} state_t;

    state_t                  state;
    logic [KW-1:0]           k;
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] x2;
    logic signed [WIDTH-1:0] term;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    term_ext;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] c;
        if (v > SMAX)      c = SMAX;
        else if (v < SMIN) c = SMIN;
        else               c = v;
        return c[WIDTH-1:0];
    endfunction

    // Q1 realignment keeps product bits [2W-2:W-1]; only -1 x -1 (or rounding) can overflow.
    function automatic logic signed [WIDTH-1:0] qmul(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ae;
        logic signed [2*WIDTH-1:0] be;
        logic signed [2*WIDTH-1:0] p;
        logic signed [PW-1:0]      pr;
        ae = {{WIDTH{a[WIDTH-1]}}, a};
        be = {{WIDTH{b[WIDTH-1]}}, b};
        p  = ae * be;
        pr = {{2{p[2*WIDTH-1]}}, p};
`ifdef TANH_ROUND_EN
        pr = pr + (PW'(1) << (WIDTH - 2));
`else
        pr = pr;
`endif
        return sat(pr >>> (WIDTH - 1));
    endfunction

    // Ratios are stored as 16-bit codes; left-align into WIDTH so wider builds zero-fill
    // and narrower builds drop LSBs. The MSB is always zero, so they stay non-negative.
    function automatic logic signed [WIDTH-1:0] ratio(input logic [KW-1:0] idx);
        logic [15:0] r16;
        logic [31:0] wide;
        case (int'(idx))
            0:       r16 = 16'h2AAA;
            1:       r16 = 16'h3333;
            2:       r16 = 16'h33CF;
            3:       r16 = 16'h33DE;
            default: r16 = 16'h33E0;
        endcase
        wide = {r16, 16'h0000};
        return wide[31 -: WIDTH];
    endfunction

    assign term_ext = {{2{term[WIDTH-1]}}, term};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            y_out <= '0;
            k     <= '0;
            xs    <= '0;
            x2    <= '0;
            term  <= '0;
            acc   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        term  <= x_in;
                        acc   <= {{2{x_in[WIDTH-1]}}, x_in};
                        xs    <= x_in;
                        k     <= KW'(1);
                        busy  <= 1'b1;
                        state <= SQR;
                    end
                end
                SQR: begin
                    x2    <= qmul(xs, xs);
                    state <= RMUL;
                end
                RMUL: begin
                    term  <= qmul(term, ratio(k - KW'(1)));
                    state <= XMUL;
                end
                XMUL: begin
                    term  <= qmul(term, x2);
                    state <= ACC;
                end
                ACC: begin
                    acc <= k[0] ? (acc - term_ext) : (acc + term_ext);
                    if (k == K_LAST) begin
                        state <= FIN;
                    end else begin
                        k     <= k + KW'(1);
                        state <= RMUL;
                    end
                end
                FIN: begin
                    y_out <= sat({{WIDTH{acc[AW-1]}}, acc});
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
